// File: rtl/magic_nor_sequencer.sv
// MAGIC crossbar sequencer: runs a NOR/NOT program over LANES rows in parallel, two cycles per op.
// Optional MAGIC_HAZARD_CHECK_EN flags and aborts ops whose destination aliases a source.

module magic_nor_lane #(
    parameter int CELLS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          col_we,
    input  logic [AW-1:0] col_addr,
    input  logic          col_bit,
    input  logic          do_init,
    input  logic          do_eval,
    input  logic          op_not,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_bit
);
    logic [CELLS-1:0] cells;
    logic va, vb;

    // Loops cover only real cells, so out-of-range addresses read 0 and write nothing.
    function automatic logic pick(input logic [CELLS-1:0] v, input logic [AW-1:0] a);
        logic r;
        r = 1'b0;
        for (int c = 0; c < CELLS; c++)
            if (a == AW'(c)) r = v[c];
        return r;
    endfunction

    assign va     = pick(cells, src_a);
    assign vb     = pick(cells, src_b);
    assign rd_bit = pick(cells, rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells <= '0;
        end else begin
            for (int c = 0; c < CELLS; c++) begin
                if (col_we && col_addr == AW'(c))
                    cells[c] <= col_bit;
                else if (do_init && dst == AW'(c))
                    cells[c] <= 1'b1;
                else if (do_eval && dst == AW'(c))
                    cells[c] <= op_not ? ~va : ~(va | vb);
            end
        end
    end
endmodule

module magic_nor_sequencer #(
    parameter int  LANES      = 8,
    parameter int  CELLS      = 32,
    parameter int  PROG_DEPTH = 16,
    localparam int AW         = $clog2(CELLS),
    localparam int PW         = $clog2(PROG_DEPTH),
    localparam int IW         = 1 + 3*AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [PW-1:0]    prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic [PW:0]      prog_len,
    input  logic             col_we,
    input  logic [AW-1:0]    col_addr,
    input  logic [LANES-1:0] col_data,
    input  logic             start,
    input  logic [AW-1:0]    rd_addr,
    output logic [LANES-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_EVAL, S_DONE} state_t;

    localparam logic [PW:0] DEPTH_L = (PW+1)'(PROG_DEPTH);

    state_t         state;
    logic [PW-1:0]  pc;
    logic [PW:0]    len;
    logic [IW-1:0]  prog_mem [PROG_DEPTH];
    logic [IW-1:0]  ir;
    logic           op_not, hazard, idle, last, col_ok, do_init, do_eval;
    logic [AW-1:0]  dst, src_a, src_b;

    assign idle    = (state == S_IDLE);
    assign ir      = prog_mem[pc];
    assign op_not  = ir[IW-1];
    assign dst     = ir[3*AW-1 -: AW];
    assign src_a   = ir[2*AW-1 -: AW];
    assign src_b   = ir[AW-1:0];
    assign last    = ({1'b0, pc} == len - 1'b1);
    assign col_ok  = col_we && idle;
    assign do_init = (state == S_INIT) && !hazard;
    assign do_eval = (state == S_EVAL);

    // Program RAM survives reset on purpose.
    always_ff @(posedge clk)
        if (prog_we && idle) prog_mem[prog_addr] <= prog_data;

`ifdef MAGIC_HAZARD_CHECK_EN
    assign hazard = (dst == src_a) || (!op_not && dst == src_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       err <= 1'b0;
        else if (idle && start && prog_len != '0)      err <= 1'b0;
        else if (state == S_INIT && hazard)            err <= 1'b1;
    end
`else
    assign hazard = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            len   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    if (prog_len != '0) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                        pc    <= '0;
                        len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_INIT: if (hazard) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= S_EVAL;
                end
                S_EVAL: if (last) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    pc    <= pc + 1'b1;
                    state <= S_INIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        magic_nor_lane #(.CELLS(CELLS), .AW(AW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .col_we   (col_ok),
            .col_addr (col_addr),
            .col_bit  (col_data[i]),
            .do_init  (do_init),
            .do_eval  (do_eval),
            .op_not   (op_not),
            .dst      (dst),
            .src_a    (src_a),
            .src_b    (src_b),
            .rd_addr  (rd_addr),
            .rd_bit   (rd_data[i])
        );
    end
endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Randomised self-checking bench for magic_nor_sequencer (LANES=32, CELLS=16) against an op-level model.
module tb_magic_nor_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [12:0] prog_data;
    logic [4:0]  prog_len;
    logic        col_we;
    logic [3:0]  col_addr;
    logic [31:0] col_data;
    logic        start;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_cells [16];
    logic [12:0] m_prog  [16];
    logic        m_err;
    int          m_steps;

    magic_nor_sequencer #(.LANES(32), .CELLS(16), .PROG_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .col_we(col_we), .col_addr(col_addr), .col_data(col_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] enc(input bit n, input int d, input int a, input int b);
        return {n, 4'(d), 4'(a), 4'(b)};
    endfunction

    task automatic load_prog(input int addr, input logic [12:0] d);
        prog_we = 1'b1; prog_addr = 4'(addr); prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        m_prog[addr] = d;
    endtask

    task automatic load_col(input int addr, input logic [31:0] d);
        col_we = 1'b1; col_addr = 4'(addr); col_data = d;
        @(negedge clk);
        col_we = 1'b0;
        m_cells[addr] = d;
    endtask

    task automatic check_cells(input string tag);
        for (int c = 0; c < 16; c++) begin
            rd_addr = 4'(c);
            #1;
            chk($sformatf("%s_cell%0d", tag, c), rd_data, m_cells[c]);
        end
        @(negedge clk);
    endtask

    // Op-level model: each op forces dst to all-ones, then evaluates from the updated array.
    task automatic model_run(input int len);
        int eff;
        bit n;
        int d, a, b;
        eff = (len > 16) ? 16 : len;
        m_steps = 2*eff;
        if (eff != 0) m_err = 1'b0;
        for (int k = 0; k < eff; k++) begin
            n = m_prog[k][12];
            d = m_prog[k][11:8];
            a = m_prog[k][7:4];
            b = m_prog[k][3:0];
`ifdef MAGIC_HAZARD_CHECK_EN
            if (d == a || (!n && d == b)) begin
                m_err   = 1'b1;
                m_steps = 2*k + 1;
                break;
            end
`endif
            m_cells[d] = '1;
            m_cells[d] = n ? ~m_cells[a] : ~(m_cells[a] | m_cells[b]);
        end
    endtask

    task automatic run_prog(input string tag, input int len, input bit interfere);
        int cyc, bcnt;
        model_run(len);
        prog_len = 5'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; bcnt = 0;
        while (!done && cyc < 200) begin
            if (busy) bcnt++;
            if (interfere && cyc == 2) begin
                start = 1'b1; col_we = 1'b1;
                col_addr = 4'($urandom); col_data = $urandom;
            end else begin
                start = 1'b0; col_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; col_we = 1'b0;
        chk({tag, "_latency"}, cyc, m_steps + 1);
        chk({tag, "_busy_cycles"}, bcnt, m_steps);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
        check_cells(tag);
    endtask

    initial begin
        logic [31:0] g22, g23;
        rst = 1'b1; prog_we = 0; prog_addr = 0; prog_data = 0; prog_len = 0;
        col_we = 0; col_addr = 0; col_data = 0; start = 0; rd_addr = 0;
        for (int c = 0; c < 16; c++) begin m_cells[c] = '0; m_prog[c] = '0; end
        m_err = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err",  {31'b0, err},  32'd0);
        check_cells("rst");

        // c17: inputs G1,G2,G3,G6,G7 in cells 0..4, lane i carries input vector i
        for (int k = 0; k < 5; k++) begin
            logic [31:0] v;
            for (int i = 0; i < 32; i++) v[i] = 1'((i >> k) & 1);
            load_col(k, v);
        end
        load_prog(0,  enc(1, 5, 0, 0));
        load_prog(1,  enc(1, 6, 1, 0));
        load_prog(2,  enc(1, 7, 2, 0));
        load_prog(3,  enc(1, 8, 3, 0));
        load_prog(4,  enc(1, 9, 4, 0));
        load_prog(5,  enc(0, 10, 5, 7));
        load_prog(6,  enc(0, 11, 7, 8));
        load_prog(7,  enc(0, 12, 6, 11));
        load_prog(8,  enc(0, 13, 11, 9));
        load_prog(9,  enc(0, 14, 10, 12));
        load_prog(10, enc(1, 15, 14, 0));
        load_prog(11, enc(0, 5, 12, 13));
        load_prog(12, enc(1, 6, 5, 0));
        run_prog("c17", 13, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bit x1, x2, x3, x6, x7, g10, g11, g16, g19;
            x1 = 1'((i >> 0) & 1); x2 = 1'((i >> 1) & 1); x3 = 1'((i >> 2) & 1);
            x6 = 1'((i >> 3) & 1); x7 = 1'((i >> 4) & 1);
            g10 = ~(x1 & x3);  g11 = ~(x3 & x6);
            g16 = ~(x2 & g11); g19 = ~(g11 & x7);
            g22[i] = ~(g10 & g16); g23[i] = ~(g16 & g19);
        end
        rd_addr = 4'd15; #1;
        chk("c17_lane0_g22",  {31'b0, rd_data[0]},  32'd0);
        chk("c17_lane31_g22", {31'b0, rd_data[31]}, 32'd1);
        chk("c17_golden_g22", rd_data, g22);
        rd_addr = 4'd6; #1;
        chk("c17_lane0_g23",  {31'b0, rd_data[0]},  32'd0);
        chk("c17_lane31_g23", {31'b0, rd_data[31]}, 32'd0);
        chk("c17_golden_g23", rd_data, g23);
        @(negedge clk);

        run_prog("len0", 0, 1'b0);

        // NOT with dst == src
        load_col(3, 32'h000000A5);
        load_prog(0, enc(1, 3, 3, 0));
        run_prog("alias", 1, 1'b0);
        rd_addr = 4'd3; #1;
`ifdef MAGIC_HAZARD_CHECK_EN
        chk("alias_cell3", rd_data, 32'h000000A5);
        chk("alias_errflag", {31'b0, err}, 32'd1);
`else
        chk("alias_cell3", rd_data, 32'h00000000);
        chk("alias_errflag", {31'b0, err}, 32'd0);
`endif
        @(negedge clk);

        // start/col_we while busy must be ignored
        load_prog(0, enc(0, 8, 0, 1));
        load_prog(1, enc(1, 9, 8, 0));
        load_prog(2, enc(0, 10, 9, 2));
        load_prog(3, enc(1, 11, 10, 0));
        run_prog("interfere", 4, 1'b1);

        // async reset at cycle 3 of a 4-op run
        prog_len = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1; #1;
        for (int c = 0; c < 16; c++) m_cells[c] = '0;
        m_err = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        check_cells("midrst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'b0, done}, 32'd0);
        end
        for (int c = 0; c < 4; c++) load_col(c, $urandom);
        run_prog("after_rst", 4, 1'b0);

        // random programs, lengths beyond depth exercise the clamp
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) load_col(c, $urandom);
            for (int p = 0; p < 16; p++)
                load_prog(p, enc(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
            run_prog($sformatf("rnd%0d", r), $urandom_range(1, 20), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
